// File: rtl/xmas_player_ctrl.sv
// rtl/xmas_player_ctrl.sv - play/pause/stop, song selection, playlist mode and LED chaser for the music box
module xmas_player_ctrl #(
  parameter int N_SONGS     = 5,
  parameter int SEL_W       = $clog2(N_SONGS),
  parameter int LED_W       = 16,
  parameter int STEP_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [3:0]       btn_pedge,
  input  logic             song_done,
  output logic             play_en,
  output logic [SEL_W-1:0] song_idx,
  output logic             song_restart,
  output logic [1:0]       mode,
  output logic [LED_W-1:0] led
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] M_SINGLE  = 2'd0;
  localparam logic [1:0] M_REP_ONE = 2'd1;
  localparam logic [1:0] M_REP_ALL = 2'd2;

  localparam int              HALF     = LED_W / 2;
  localparam int              TICK_W   = $clog2(STEP_CYCLES);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(STEP_CYCLES - 1);
  localparam logic [SEL_W-1:0]  IDX_MAX  = SEL_W'(N_SONGS - 1);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [1:0]        mode_q, mode_d;
  logic              pending_q, pending_d;
  logic              restart_q, restart_d;
  logic              play_en_q, play_en_d;
  logic [HALF-1:0]   chaser_q, chaser_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [LED_W-1:0]  led_q, led_d;

  logic             btn_play, btn_next, btn_prev, btn_nav, btn_mode;
  logic [SEL_W-1:0] idx_inc, idx_dec;

  // Simultaneous next+prev cancel each other out.
  assign btn_play = btn_pedge[0];
  assign btn_next = btn_pedge[1] & ~btn_pedge[2];
  assign btn_prev = btn_pedge[2] & ~btn_pedge[1];
  assign btn_nav  = btn_next | btn_prev;
  assign btn_mode = btn_pedge[3];

  assign idx_inc = (idx_q == IDX_MAX) ? '0 : idx_q + SEL_W'(1);
  assign idx_dec = (idx_q == '0) ? IDX_MAX : idx_q - SEL_W'(1);

  // Player FSM, song selection, pending-restart bookkeeping and mode cycling.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    restart_d = 1'b0;

    if (btn_play) begin
      case (state_q)
        ST_STOP: begin
          state_d   = ST_PLAY;
          restart_d = 1'b1;
          pending_d = 1'b0;
        end
        ST_PLAY:  state_d = ST_PAUSE;
        ST_PAUSE: begin
          state_d   = ST_PLAY;
          restart_d = pending_q;
          pending_d = 1'b0;
        end
        default:  state_d = ST_STOP;
      endcase
    end

    // Navigation is judged against the state this cycle lands in, so a
    // pause-and-skip in one cycle defers the restart until resume.
    if (btn_nav) begin
      idx_d = btn_next ? idx_inc : idx_dec;
      if (state_d == ST_PLAY) begin
        restart_d = 1'b1;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (song_done && state_q == ST_PLAY && state_d == ST_PLAY) begin
      case (mode_q)
        M_REP_ONE: restart_d = 1'b1;
        M_REP_ALL: begin
          idx_d     = idx_inc;
          restart_d = 1'b1;
        end
        default:   state_d = ST_STOP;
      endcase
    end

    // Mode code 3 behaves as SINGLE, so it steps on to REPEAT_ONE.
    if (btn_mode) begin
      case (mode_q)
        M_REP_ONE: mode_d = M_REP_ALL;
        M_REP_ALL: mode_d = M_SINGLE;
        default:   mode_d = M_REP_ONE;
      endcase
    end

    play_en_d = (state_d == ST_PLAY);
  end

  // Chaser timebase: runs in PLAY, frozen in PAUSE, counter cleared in STOP.
  always_comb begin
    chaser_d = chaser_q;
    tick_d   = tick_q;
    if (state_q == ST_PLAY) begin
      if (tick_q == TICK_MAX) begin
        tick_d   = '0;
        chaser_d = {chaser_q[HALF-2:0], chaser_q[HALF-1]};
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end else if (state_q != ST_PAUSE) begin
      tick_d = '0;
    end
  end

  // LED image built from next-state values so it changes with the other outputs.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_SONGS; i++) begin
      led_d[i] = (idx_d == SEL_W'(i));
    end
    led_d[HALF-1 -: 2]      = mode_d;
    led_d[LED_W-1 -: HALF] = (state_d == ST_STOP) ? '0 : chaser_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= ST_STOP;
      idx_q     <= '0;
      mode_q    <= M_SINGLE;
      pending_q <= 1'b0;
      restart_q <= 1'b0;
      play_en_q <= 1'b0;
      chaser_q  <= HALF'(1);
      tick_q    <= '0;
      led_q     <= LED_W'(1);
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      restart_q <= restart_d;
      play_en_q <= play_en_d;
      chaser_q  <= chaser_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
    end
  end

  assign play_en      = play_en_q;
  assign song_idx     = idx_q;
  assign song_restart = restart_q;
  assign mode         = mode_q;
  assign led          = led_q;

endmodule

// File: tb/tb_xmas_player_ctrl.sv
// tb/tb_xmas_player_ctrl.sv - directed self-checking bench for xmas_player_ctrl
module tb_xmas_player_ctrl;

  localparam int N_SONGS = 5;
  localparam int SEL_W   = $clog2(N_SONGS);
  localparam int LED_W   = 16;

  logic             clk;
  logic             reset_p;
  logic [3:0]       btn_pedge;
  logic             song_done;
  logic             play_en;
  logic [SEL_W-1:0] song_idx;
  logic             song_restart;
  logic [1:0]       mode;
  logic [LED_W-1:0] led;

  int n_cmp;
  int n_err;

  xmas_player_ctrl #(
    .N_SONGS(N_SONGS),
    .LED_W(LED_W),
    .STEP_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .btn_pedge(btn_pedge),
    .song_done(song_done),
    .play_en(play_en),
    .song_idx(song_idx),
    .song_restart(song_restart),
    .mode(mode),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs for one clock; return at the following falling edge.
  task automatic step(input logic [3:0] b, input logic d);
    btn_pedge = b;
    song_done = d;
    @(negedge clk);
    btn_pedge = 4'b0;
    song_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset_p   = 1'b1;
    btn_pedge = 4'b0;
    song_done = 1'b0;
    idle(2);
    reset_p = 1'b0;

    check("rst_play_en", play_en, 0);
    check("rst_idx", song_idx, 0);
    check("rst_mode", mode, 0);
    check("rst_restart", song_restart, 0);
    check("rst_led", led, 16'h0001);

    // start playing, finish in SINGLE
    step(4'b0001, 1'b0);
    check("start_play_en", play_en, 1);
    check("start_restart", song_restart, 1);
    check("start_led", led, 16'h0101);
    idle(1);
    check("start_restart_clr", song_restart, 0);
    step(4'b0000, 1'b1);
    check("single_done_play_en", play_en, 0);
    check("single_done_idx", song_idx, 0);
    check("single_done_restart", song_restart, 0);
    check("single_done_led", led, 16'h0001);

    // navigation in STOP and wrap-around
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b0);
    check("nav_idx4", song_idx, 4);
    check("nav_stop_no_pulse", song_restart, 0);
    step(4'b0010, 1'b0);
    check("next_wrap", song_idx, 0);
    step(4'b0100, 1'b0);
    check("prev_wrap", song_idx, 4);
    step(4'b0110, 1'b0);
    check("both_nav_idx", song_idx, 4);
    check("both_nav_pulse", song_restart, 0);
    check("stop_led_idx4", led, 16'h0010);

    // pause, skip twice, resume with a single deferred restart
    step(4'b0001, 1'b0);
    check("play2_restart", song_restart, 1);
    idle(1);
    step(4'b0001, 1'b0);
    check("pause_play_en", play_en, 0);
    check("pause_restart", song_restart, 0);
    check("pause_led", led, 16'h0110);
    step(4'b0010, 1'b0);
    check("pause_next1_pulse", song_restart, 0);
    step(4'b0010, 1'b0);
    check("pause_next2_idx", song_idx, 1);
    check("pause_next2_pulse", song_restart, 0);
    step(4'b0001, 1'b0);
    check("resume_play_en", play_en, 1);
    check("resume_restart", song_restart, 1);
    check("resume_idx", song_idx, 1);
    idle(1);
    check("resume_restart_clr", song_restart, 0);

    // next while playing, then pause+next in one cycle
    step(4'b0010, 1'b0);
    check("play_next_idx", song_idx, 2);
    check("play_next_pulse", song_restart, 1);
    step(4'b0011, 1'b0);
    check("pause_next_play_en", play_en, 0);
    check("pause_next_idx", song_idx, 3);
    check("pause_next_pulse", song_restart, 0);
    step(4'b0001, 1'b0);
    check("pause_next_resume_pulse", song_restart, 1);

    // repeat modes
    step(4'b1000, 1'b0);
    check("mode_rep_one", mode, 1);
    check("mode_btn_no_pulse", song_restart, 0);
    step(4'b0000, 1'b1);
    check("rep_one_pulse", song_restart, 1);
    check("rep_one_idx", song_idx, 3);
    check("rep_one_play_en", play_en, 1);
    step(4'b1000, 1'b0);
    check("mode_rep_all", mode, 2);
    check("rep_all_led_low", led[7:0], 8'h88);
    step(4'b0010, 1'b0);
    check("rep_all_next_idx", song_idx, 4);
    step(4'b0000, 1'b1);
    check("rep_all_wrap_idx", song_idx, 0);
    check("rep_all_wrap_pulse", song_restart, 1);
    step(4'b0100, 1'b1);
    check("prev_beats_done_idx", song_idx, 4);
    check("prev_beats_done_pulse", song_restart, 1);
    step(4'b0100, 1'b1);
    check("prev_beats_done2_idx", song_idx, 3);
    idle(1);
    check("prev_beats_done2_clr", song_restart, 0);
    step(4'b0000, 1'b1);
    check("rep_all_idx4", song_idx, 4);

    // asynchronous reset mid-PLAY
    #2 reset_p = 1'b1;
    #1;
    check("async_rst_idx", song_idx, 0);
    check("async_rst_play_en", play_en, 0);
    @(negedge clk);
    check("rst2_mode", mode, 0);
    check("rst2_restart", song_restart, 0);
    check("rst2_led", led, 16'h0001);
    reset_p = 1'b0;

    // chaser in PLAY with four cycles per step
    step(4'b0001, 1'b0);
    check("chase_0", led[15:8], 8'h01);
    idle(3);
    check("chase_hold", led[15:8], 8'h01);
    idle(1);
    check("chase_1", led[15:8], 8'h02);
    for (int k = 2; k <= 9; k++) begin
      logic [7:0] exp_pos;
      exp_pos = 8'h01 << (k % 8);
      idle(4);
      check($sformatf("chase_%0d", k), led[15:8], exp_pos);
    end
    step(4'b0001, 1'b0);
    check("chase_pause", led[15:8], 8'h02);
    idle(8);
    check("chase_frozen", led[15:8], 8'h02);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b1);
    check("chase_stop_led", led, 16'h0001);
    idle(5);
    check("chase_stop_hold", led, 16'h0001);
    step(4'b0001, 1'b0);
    check("chase_pos_kept", led[15:8], 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
